// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between N_REQ byte sources.
// tx_status is synchronized before use; every transfer ends with an ack pulse (plus err on timeout).
module uart_tx_arbiter #(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic                    err,
  output logic                    tx_ready,
  output logic [DATA_W-1:0]       tx_byte,
  input  logic                    tx_status,
  output logic                    busy,
  output logic [1:0]              grant_id,
  output logic [7:0]              sent_count
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0] LAST_INIT = 2'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t            state;
  logic              st_meta;
  logic              st_s;
  logic [CNT_W-1:0]  tmo_cnt;
  logic [1:0]        last;
  logic              pick_valid;
  logic [1:0]        pick_id;
  logic [DATA_W-1:0] pick_byte;
  logic [N_REQ-1:0]  grant_onehot;

  // tx_status lives in the baud-clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_meta <= 1'b0;
      st_s    <= 1'b0;
    end else begin
      st_meta <= tx_status;
      st_s    <= st_meta;
    end
  end

  // Search upward from the requester after the last owner, wrapping around
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!pick_valid && req[i] && (((int'(last) + k) % N_REQ) == i)) begin
          pick_valid = 1'b1;
          pick_id    = 2'(i);
        end
      end
    end
  end

  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_id == 2'(i)) begin
        pick_byte = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant_onehot[i] = (grant_id == 2'(i));
    end
  end

  // ack/err/sent_count are set on the way into DONE so they show during the DONE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ack        <= '0;
      err        <= 1'b0;
      tx_ready   <= 1'b0;
      tx_byte    <= '0;
      busy       <= 1'b0;
      grant_id   <= '0;
      sent_count <= '0;
      tmo_cnt    <= '0;
      last       <= LAST_INIT;
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_id <= pick_id;
            tx_byte  <= pick_byte;
            tx_ready <= 1'b1;
            busy     <= 1'b1;
            tmo_cnt  <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (st_s) begin
            tx_ready <= 1'b0;
            tmo_cnt  <= '0;
            state    <= DRAIN;
          end else if (tmo_cnt == CNT_LAST) begin
            tx_ready <= 1'b0;
            ack      <= grant_onehot;
            err      <= 1'b1;
            state    <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (!st_s) begin
            ack        <= grant_onehot;
            sent_count <= sent_count + 8'd1;
            state      <= DONE;
          end
        end
        DONE: begin
          last  <= grant_id;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transmitter model, transaction-level reference model
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_uart_tx_arbiter;

  localparam int N_REQ   = 2;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  ack;
  logic        err;
  logic        tx_ready;
  logic [7:0]  tx_byte;
  logic        tx_status = 1'b0;
  logic        busy;
  logic [1:0]  grant_id;
  logic [7:0]  sent_count;

  uart_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .err(err),
    .tx_ready(tx_ready), .tx_byte(tx_byte), .tx_status(tx_status), .busy(busy),
    .grant_id(grant_id), .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string name;
    int    act;
    int    want;
  } lit_t;
  lit_t lit_q[$];

  task automatic compareValue(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("[TB] FAIL %s: got 'h%0h expected 'h%0h at cycle %0d", name, act, want, cyc);
    end
  endtask

  // Hand-computed expectations are queued and evaluated by the compare process
  task automatic checkOutput(input string name, input int act, input int want);
    lit_t e;
    e.name = name;
    e.act  = act;
    e.want = want;
    lit_q.push_back(e);
  endtask

  // Transmitter: goes busy busy_delay cycles after seeing ready, stays busy busy_len cycles
  bit         tx_en = 1'b1;
  int         busy_delay = 5;
  int         busy_len = 80;
  int         tx_phase = 0;
  int         tx_cnt = 0;
  int         rise_n = 0, fall_n = 0, rise_cyc = 0, fall_cyc = 0;
  logic [7:0] sent_q[$];

  always @(negedge clk) begin
    if (rst) begin
      tx_status = 1'b0;
      tx_phase  = 0;
      tx_cnt    = 0;
    end else begin
      case (tx_phase)
        0: if (tx_en && tx_ready) begin tx_phase = 1; tx_cnt = 0; end
        1: begin
          tx_cnt++;
          if (tx_cnt == busy_delay) begin
            tx_status = 1'b1;
            rise_cyc  = cyc;
            rise_n++;
            sent_q.push_back(tx_byte);
            tx_phase  = 2;
            tx_cnt    = 0;
          end
        end
        default: begin
          tx_cnt++;
          if (tx_cnt == busy_len) begin
            tx_status = 1'b0;
            fall_cyc  = cyc;
            fall_n++;
            tx_phase  = 0;
          end
        end
      endcase
    end
  end

  function automatic int rr_pick(input int last, input logic [1:0] r);
    for (int k = 1; k <= N_REQ; k++) begin
      if (r[(last + k) % N_REQ]) return (last + k) % N_REQ;
    end
    return 0;
  endfunction

  // Reference model: one transfer at a time, timing derived from the tx_status edges
  int         m_last = N_REQ - 1, m_owner = 0, m_sent = 0, m_start = 0;
  int         rise_base = 0, fall_base = 0;
  bit         m_active = 1'b0;
  logic [7:0] m_byte = '0;
  int         ready_run = 0, last_len = 0, lit_rd = 0;
  bit         r_ok, is_to, is_fin, exp_ready;
  int         exp_cnt;
  logic [1:0] exp_ack;

  always @(negedge clk) begin
    while (lit_rd < lit_q.size()) begin
      compareValue(lit_q[lit_rd].name, lit_q[lit_rd].act, lit_q[lit_rd].want);
      lit_rd++;
    end
    if (tx_ready) ready_run++;
    else begin
      if (ready_run > 0) last_len = ready_run;
      ready_run = 0;
    end
    if (rst) begin
      compareValue("outputs_in_reset", int'({ack, err, tx_ready, busy, grant_id, sent_count, tx_byte}), 0);
      m_active  = 1'b0;
      m_last    = N_REQ - 1;
      m_owner   = 0;
      m_sent    = 0;
      ready_run = 0;
    end else begin
      r_ok      = m_active && (rise_n > rise_base);
      is_to     = m_active && (cyc == m_start + TIMEOUT) && !(r_ok && (rise_cyc + 2 <= m_start + TIMEOUT - 1));
      is_fin    = m_active && !is_to && (fall_n > fall_base) && (cyc == fall_cyc + 3);
      exp_ack   = (is_to || is_fin) ? 2'(1 << m_owner) : 2'b00;
      exp_cnt   = (m_sent + (is_fin ? 1 : 0)) % 256;
      exp_ready = m_active && (cyc < m_start + TIMEOUT) && !(r_ok && (cyc >= rise_cyc + 3));
      compareValue("ack", ack, exp_ack);
      compareValue("err", err, is_to);
      compareValue("tx_ready", tx_ready, exp_ready);
      compareValue("busy", busy, m_active);
      compareValue("sent_count", sent_count, exp_cnt);
      compareValue("grant_id", grant_id, m_owner);
      if (m_active) compareValue("tx_byte", tx_byte, m_byte);
      if (is_to || is_fin) begin
        m_sent   = exp_cnt;
        m_last   = m_owner;
        m_active = 1'b0;
      end else if (!m_active && (req != 2'b00)) begin
        m_owner   = rr_pick(m_last, req);
        m_byte    = req_data[m_owner*8 +: 8];
        m_start   = cyc + 1;
        rise_base = rise_n;
        fall_base = fall_n;
        m_active  = 1'b1;
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] r, input logic [15:0] d);
    @(posedge clk);
    #1;
    req      = r;
    req_data = d;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic waitAck(output logic [1:0] a, output logic e, output int c, output int s);
    bit seen = 1'b0;
    a = '0; e = 1'b0; c = 0; s = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        seen = 1'b1; a = ack; e = err; c = cyc; s = sent_count;
      end
    end
    if (!seen) checkOutput("ack_wait_expired", 0, 1);
  endtask

  task automatic waitDrain();
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (busy && !tx_ready) seen = 1'b1;
    end
    if (!seen) checkOutput("drain_wait_expired", 0, 1);
  endtask

  task automatic waitReady(output int c);
    bit seen = 1'b0;
    c = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (tx_ready) begin seen = 1'b1; c = cyc; end
    end
    if (!seen) checkOutput("ready_wait_expired", 0, 1);
  endtask

  function automatic int byteAt(input int idx);
    return (idx < sent_q.size()) ? int'(sent_q[idx]) : 'hFFF;
  endfunction

  logic [1:0] a;
  logic       e;
  int         c, s, base, c_ack, c_rdy;
  logic [1:0] acks[4];

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_sent_count", sent_count, 0);
    checkOutput("reset_grant_id", grant_id, 0);

    // Single requester
    base = sent_q.size();
    applyStimulus(2'b01, 16'h0041);
    waitAck(a, e, c, s);
    applyStimulus(2'b00, 16'h0041);
    checkOutput("t1_ack", a, 'b01);
    checkOutput("t1_err", e, 0);
    checkOutput("t1_sent_count", s, 1);
    checkOutput("t1_ready_len_7_to_8", int'(last_len >= 7 && last_len <= 8), 1);
    checkOutput("t1_byte", byteAt(base), 'h41);

    // Contention from a fresh reset: requester 0 first, then alternating
    doReset();
    base = sent_q.size();
    applyStimulus(2'b11, 16'h55AA);
    for (int k = 0; k < 4; k++) begin
      waitAck(a, e, c, s);
      acks[k] = a;
    end
    applyStimulus(2'b00, 16'h55AA);
    checkOutput("t2_ack0", acks[0], 'b01);
    checkOutput("t2_ack1", acks[1], 'b10);
    checkOutput("t2_ack2", acks[2], 'b01);
    checkOutput("t2_ack3", acks[3], 'b10);
    checkOutput("t2_sent_count", s, 4);
    checkOutput("t2_byte0", byteAt(base), 'hAA);
    checkOutput("t2_byte1", byteAt(base + 1), 'h55);
    checkOutput("t2_byte2", byteAt(base + 2), 'hAA);
    checkOutput("t2_byte3", byteAt(base + 3), 'h55);

    // Timeout: transmitter never answers
    tx_en = 1'b0;
    base = sent_q.size();
    applyStimulus(2'b10, 16'h3300);
    waitAck(a, e, c, s);
    applyStimulus(2'b00, 16'h3300);
    tx_en = 1'b1;
    checkOutput("t3_ack", a, 'b10);
    checkOutput("t3_err", e, 1);
    checkOutput("t3_sent_count_held", s, 4);
    checkOutput("t3_ready_len", last_len, 16);
    checkOutput("t3_no_byte_sent", sent_q.size() - base, 0);

    // Queued arrival during DRAIN
    base = sent_q.size();
    applyStimulus(2'b01, 16'h5541);
    waitDrain();
    applyStimulus(2'b11, 16'h5541);
    @(negedge clk);
    checkOutput("t4_drain_byte", tx_byte, 'h41);
    checkOutput("t4_drain_ready", tx_ready, 0);
    waitAck(a, e, c_ack, s);
    checkOutput("t4_ack0", a, 'b01);
    applyStimulus(2'b10, 16'h5541);
    waitReady(c_rdy);
    checkOutput("t4_ack_to_ready", c_rdy - c_ack, 2);
    checkOutput("t4_second_byte", tx_byte, 'h55);
    waitAck(a, e, c, s);
    applyStimulus(2'b00, 16'h5541);
    checkOutput("t4_ack1", a, 'b10);
    checkOutput("t4_sent_count", s, 6);
    checkOutput("t4_bytes", (byteAt(base) << 8) | byteAt(base + 1), 'h4155);

    // Reset while draining
    applyStimulus(2'b01, 16'h55AA);
    waitDrain();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 2'b11;
    @(negedge clk);
    checkOutput("t5_ack", ack, 0);
    checkOutput("t5_tx_ready", tx_ready, 0);
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_tx_byte", tx_byte, 0);
    checkOutput("t5_sent_count", sent_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    waitReady(c_rdy);
    checkOutput("t5_first_grant", grant_id, 0);
    checkOutput("t5_first_byte", tx_byte, 'hAA);
    waitAck(a, e, c, s);
    applyStimulus(2'b00, 16'h55AA);
    checkOutput("t5_ack_after_reset", a, 'b01);

    // sent_count wraps after 256 good bytes
    doReset();
    busy_len = 4;
    applyStimulus(2'b01, 16'h0041);
    for (int k = 0; k < 256; k++) begin
      waitAck(a, e, c, s);
      if (k == 254) checkOutput("t6_count_255", s, 255);
    end
    applyStimulus(2'b00, 16'h0041);
    checkOutput("t6_count_wrapped", s, 0);
    checkOutput("t6_last_ack", a, 'b01);

    repeat (4) @(negedge clk);
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART `transmitter` between up to four byte sources, such as the result-matrix dump FSM and a status/echo source. It grants one requester at a time and drives the transmitter's `ready`/`data` inputs. It watches `tx_status` through a synchronizer to detect acceptance and completion, then returns a per-requester acknowledge. It sits between the memory-to-TX sequencers and the `transmitter`/`baudrate` pair, on the system clock.

## Interface
- `N_REQ`, default 2: number of requesters; legal range 2..4.
- `DATA_W`, default 8: byte width.
- `TIMEOUT`, default 1_000_000: clk cycles allowed for `tx_status` to rise after `tx_ready`.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  N_REQ  per-requester level request; held high with stable data until that requester's `ack`.
- `req_data`  in  N_REQ*DATA_W  requester i's byte is `req_data[i*DATA_W +: DATA_W]`.
- `ack`  out  N_REQ  one-cycle pulse to the served requester when its byte is finished or aborted.
- `err`  out  1  one-cycle pulse coincident with `ack` when the transfer timed out.
- `tx_ready`  out  1  connects to transmitter `ready`.
- `tx_byte`  out  DATA_W  connects to transmitter `data`; stable while `tx_ready` or busy.
- `tx_status`  in  1  transmitter busy flag; baud-clock domain, so it is treated as asynchronous.
- `busy`  out  1  high in any state except IDLE.
- `grant_id`  out  2  index of the current or most recent owner.
- `sent_count`  out  8  bytes completed without error; wraps 255→0.

## Operation
- `tx_status` passes through a 2-flop synchronizer, giving `st_s`. All decisions use `st_s`.
- State IDLE:
  - If any `req` bit is high, pick the first set bit searching upward from `(last+1) mod N_REQ`, wrapping.
  - Register `grant_id`, latch `tx_byte` from `req_data`, and go to ISSUE.
  - Otherwise stay in IDLE.
- State ISSUE:
  - `tx_ready`=1 and the timeout counter increments.
  - If `st_s`=1, go to DRAIN and clear the counter.
  - Else, if the counter reaches `TIMEOUT-1`, go to DONE with the error flag set.
- State DRAIN:
  - `tx_ready`=0.
  - Wait for `st_s`=0, then go to DONE.
  - No timeout is applied here; the transmitter always finishes a frame.
- State DONE (one cycle):
  - Pulse `ack[grant_id]`.
  - Pulse `err` if the error flag is set; otherwise increment `sent_count`.
  - Set `last`=`grant_id`, clear the error flag, and go to IDLE.
- After reset, `last`=`N_REQ-1`, so requester 0 wins the first contention.
- A `req` that drops before it is granted is simply not served. `req` of the owner is not re-checked after grant; the latched byte is sent regardless.
- A requester that keeps `req` high after `ack` is re-eligible next IDLE, but only after every other pending requester has been served once (fairness).
- `req` bits at indices ≥ `N_REQ` do not exist; `ack` is only ever one-hot or zero.

## Timing
- Reset values: state IDLE; `ack`, `err`, `tx_ready`, `busy`, `grant_id`, `sent_count`, `tx_byte`, timeout counter and both sync flops all 0; `last`=`N_REQ-1`.
- Reset is effective mid-transfer. The arbiter returns to IDLE immediately with no `ack`. The transmitter shares `rst`, so any in-flight frame is also discarded.
- `req` high in cycle T (state IDLE) gives `tx_ready`=1 and `busy`=1 from T+1.
- `tx_status` rising edge gives `st_s` rising 2 to 3 cycles later. `tx_ready` falls the cycle after `st_s` is seen high, which guarantees the bclk-domain transmitter has sampled it.
- `tx_status` falling edge gives `ack` 3 to 4 cycles later. IDLE follows `ack` by one cycle.
- Back-to-back issue: minimum 2 cycles from `ack` to the next `tx_ready` (DONE→IDLE→ISSUE).
- Simultaneous requests in the same IDLE cycle resolve purely by round-robin order.
- A new `req` arriving while `busy` is queued; it is evaluated at the next IDLE.
- `sent_count` updates in the DONE cycle, visible together with `ack`.

## Test plan
- Single requester: N_REQ=2, `req`=01, byte 0x41. Transmitter model goes busy 5 cycles after ready and stays busy 80 cycles. Required: `tx_ready` for 7 to 8 cycles, `tx_byte`=0x41, `ack`=01 pulse, `err`=0, `sent_count`=1.
- Contention: `req`=11 held continuously with bytes 0xAA (req0) and 0x55 (req1), 4 bytes total. Required: transmit order 0xAA, 0x55, 0xAA, 0x55; `ack` alternates 01, 10; `sent_count`=4.
- Timeout: TIMEOUT=16, model never asserts busy, `req`=10. Required: `tx_ready` high for exactly 16 cycles, then `ack`=10 with `err`=1; `sent_count` unchanged.
- Queued arrival: req0 issued, then `req1` raised during DRAIN. Required: no `tx_byte` change during DRAIN; req1 gets `tx_ready` exactly 2 cycles after req0's `ack`.
- Reset mid-operation: assert `rst` in DRAIN. Required: all outputs 0 in the same cycle; no `ack`. After release, with `req`=11, requester 0 is granted first.
- Counter wrap: 256 error-free bytes from req0. Required: `sent_count` reads 0 after the 256th `ack`.
